// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous clock in I_CLK cycles.
// Optional glitch filter on the synchronised level: define CLK_METER_GLITCH_FILTER_EN.
`timescale 1ns / 1ps
module clk_period_meter #(
    parameter int CNT_W   = 28,
    parameter int TIMEOUT = 100000000
) (
    input  logic             I_CLK,
    input  logic             Rst,
    input  logic             I_SIG,
    output logic [CNT_W-1:0] O_PERIOD,
    output logic [CNT_W-1:0] O_HIGH,
    output logic             O_VALID,
    output logic             O_STUCK
);
    localparam logic [0:0]       IDLE     = 1'b0;
    localparam logic [0:0]       MEAS     = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic             s1_q, s2_q, s3_q;
    logic             lvl;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] hreg_q, hreg_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;
    logic [0:0]       state_q, state_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge I_CLK) begin
        if (Rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= I_SIG;
            s2_q <= s1_q;
            s3_q <= lvl;
        end
    end

`ifdef CLK_METER_GLITCH_FILTER_EN
    logic       filt_q, filt_d;
    logic [1:0] run_q, run_d;

    // s1 already holds the next s2 sample, so the fourth differing cycle is known one edge early.
    always_comb begin
        filt_d = filt_q;
        run_d  = 2'd0;
        if (s2_q != filt_q) begin
            if (run_q == 2'd2) begin
                if (s1_q != filt_q) filt_d = s2_q;
            end else begin
                run_d = run_q + 2'd1;
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (Rst) begin
            filt_q <= 1'b0;
            run_q  <= 2'd0;
        end else begin
            filt_q <= filt_d;
            run_q  <= run_d;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = s2_q;
`endif

    assign rise    = lvl & ~s3_q;
    assign fall    = ~lvl & s3_q;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d    = cnt_inc;
        hreg_d   = hreg_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        stuck_d  = stuck_q;
        state_d  = state_q;
        if (fall) hreg_d = cnt_inc;
        // A rise always beats a simultaneous timeout.
        if (rise) begin
            cnt_d   = '0;
            stuck_d = 1'b0;
            state_d = MEAS;
            if (state_q == MEAS) begin
                period_d = cnt_inc;
                high_d   = hreg_q;
                valid_d  = 1'b1;
            end
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            stuck_d = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (Rst) begin
            cnt_q    <= '0;
            hreg_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
            state_q  <= IDLE;
        end else begin
            cnt_q    <= cnt_d;
            hreg_q   <= hreg_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            stuck_q  <= stuck_d;
            state_q  <= state_d;
        end
    end

    assign O_PERIOD = period_q;
    assign O_HIGH   = high_q;
    assign O_VALID  = valid_q;
    assign O_STUCK  = stuck_q;
endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: reset, clean clock, duty change, stuck, saturation, glitch.
`timescale 1ns / 1ps
module tb_clk_period_meter;
    localparam int CNT_W = 28;
`ifdef CLK_METER_GLITCH_FILTER_EN
    localparam int FD = 3;
    localparam int H0 = 4;
`else
    localparam int FD = 0;
    localparam int H0 = 3;
`endif

    logic             clk, rst, sig, sig_sat;
    logic [CNT_W-1:0] period, high;
    logic             valid, stuck;
    logic [5:0]       period_sat, high_sat;
    logic             valid_sat, stuck_sat;

    int   tests, fails;
    int   idx, nvalid, first_idx, dbl, nvalid_sat;
    logic prev_valid;
    int   per_log[$];
    int   high_log[$];
    int   gl_per[$];
    int   gl_high[$];

    clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(64)) dut (
        .I_CLK(clk), .Rst(rst), .I_SIG(sig),
        .O_PERIOD(period), .O_HIGH(high), .O_VALID(valid), .O_STUCK(stuck)
    );

    clk_period_meter #(.CNT_W(6), .TIMEOUT(63)) dut_sat (
        .I_CLK(clk), .Rst(rst), .I_SIG(sig_sat),
        .O_PERIOD(period_sat), .O_HIGH(high_sat), .O_VALID(valid_sat), .O_STUCK(stuck_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t required < 200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One I_CLK cycle: drive inputs, wait for the edge, then log any strobe.
    task automatic step(input logic s, input logic ss);
        sig     = s;
        sig_sat = ss;
        @(posedge clk);
        #1;
        idx++;
        if (valid === 1'b1) begin
            nvalid++;
            per_log.push_back(int'(period));
            high_log.push_back(int'(high));
            if (first_idx == 0) first_idx = idx;
            if (prev_valid === 1'b1) dbl++;
        end
        prev_valid = valid;
        if (valid_sat === 1'b1) nvalid_sat++;
    endtask

    task automatic drive(input int p, input int h, input bit on_sat);
        for (int i = 0; i < p; i++) begin
            if (on_sat) step(1'b0, i < h);
            else        step(i < h, 1'b0);
        end
    endtask

    task automatic clear_log();
        idx       = 0;
        nvalid    = 0;
        first_idx = 0;
        dbl       = 0;
        per_log.delete();
        high_log.delete();
    endtask

    initial begin
        tests = 0; fails = 0; nvalid_sat = 0; prev_valid = 1'b0;
        rst = 1'b1; sig = 1'b0; sig_sat = 1'b0;
        clear_log();
`ifdef CLK_METER_GLITCH_FILTER_EN
        gl_per  = '{12, 20, 20};
        gl_high = '{8, 10, 10};
`else
        gl_per  = '{12, 6, 14, 6, 14, 6};
        gl_high = '{8, 4, 4, 4, 4, 4};
`endif

        // Reset held 3 cycles with the input toggling.
        step(1'b1, 1'b1); step(1'b0, 1'b0); step(1'b1, 1'b1);
        check("rst_period", period, 0);
        check("rst_high", high, 0);
        check("rst_valid", valid, 0);
        check("rst_stuck", stuck, 0);
        check("rst_sat_period", period_sat, 0);
        check("rst_sat_stuck", stuck_sat, 0);
        check("rst_no_strobe", nvalid, 0);
        rst = 1'b0;
        repeat (4) step(1'b0, 1'b0);
        check("post_rst_stuck", stuck, 0);

        // Clean clock, period 10 high 5, five periods.
        clear_log();
        drive(10, 5, 1'b0);
        repeat (2 + FD) step(1'b1, 1'b0);
        check("clean_first_rise_no_valid", nvalid, 0);
        repeat (3 - FD) step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        repeat (3) drive(10, 5, 1'b0);
        check("clean_valid_count", nvalid, 4);
        check("clean_first_valid_step", first_idx, 13 + FD);
        check("clean_no_double_valid", dbl, 0);
        for (int i = 0; i < 4; i++) begin
            check("clean_period", per_log[i], 10);
            check("clean_high", high_log[i], 5);
        end
        check("clean_not_stuck", stuck, 0);

        // Input stops low: stuck 64 cycles after the last accepted rise.
        nvalid = 0;
        while (stuck !== 1'b1 && idx < 300) step(1'b0, 1'b0);
        check("stuck_latency", idx, 107 + FD);
        check("stuck_level", stuck, 1);
        check("stuck_no_valid", nvalid, 0);
        check("stuck_period_held", period, 10);
        check("stuck_high_held", high, 5);

        // Restart with period 12 at a short duty, then switch to high 8.
        clear_log();
        for (int k = 1; k <= 12; k++) begin
            step(k <= H0, 1'b0);
            if (k == 2 + FD) check("restart_stuck_held", stuck, 1);
            if (k == 3 + FD) begin
                check("restart_stuck_clear", stuck, 0);
                check("restart_no_valid", nvalid, 0);
            end
        end
        repeat (2) drive(12, H0, 1'b0);
        repeat (3) drive(12, 8, 1'b0);
        check("duty_valid_count", nvalid, 5);
        check("duty_first_valid_step", first_idx, 15 + FD);
        check("duty_no_double_valid", dbl, 0);
        for (int i = 0; i < 5; i++) begin
            check("duty_period", per_log[i], 12);
            check("duty_high", high_log[i], (i < 3) ? H0 : 8);
        end

        // Period 20 high 10 with a 2-cycle low glitch inside the high phase.
        clear_log();
        repeat (3) begin
            repeat (4) step(1'b1, 1'b0);
            repeat (2) step(1'b0, 1'b0);
            repeat (4) step(1'b1, 1'b0);
            repeat (10) step(1'b0, 1'b0);
        end
        check("glitch_valid_count", nvalid, gl_per.size());
        for (int i = 0; i < gl_per.size(); i++) begin
            check("glitch_period", per_log[i], gl_per[i]);
            check("glitch_high", high_log[i], gl_high[i]);
        end

        // Narrow counter: period 70 always times out before the next rise.
        nvalid_sat = 0;
        repeat (2) drive(70, 35, 1'b1);
        check("sat_stuck_before_rise", stuck_sat, 1);
        repeat (3 + FD) step(1'b0, 1'b1);
        check("sat_stuck_clear", stuck_sat, 0);
        repeat (32 - FD) step(1'b0, 1'b1);
        repeat (35) step(1'b0, 1'b0);
        check("sat_stuck_again", stuck_sat, 1);
        check("sat_no_valid", nvalid_sat, 0);
        check("sat_period", period_sat, 0);
        check("sat_high", high_sat, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
